// File: rtl/crypto_pkg.sv
// Shared types and constants for the scalar-crypto sequencing controller.
// Holds the FSM state encoding, default timeout and instruction field map.
package crypto_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  localparam int unsigned TIMEOUT_DEFAULT = 15;
  localparam int unsigned INSN_W          = 20;
  localparam int unsigned CNT_W           = 4;

  // crypto_instruction field map: block-size select, then one-hot op groups
  localparam int unsigned BS_HI     = 19;
  localparam int unsigned BS_LO     = 18;
  localparam int unsigned AES_HI    = 17;
  localparam int unsigned AES_LO    = 14;
  localparam int unsigned SHA256_HI = 13;
  localparam int unsigned SHA256_LO = 10;
  localparam int unsigned SHA512_HI = 9;
  localparam int unsigned SHA512_LO = 4;
  localparam int unsigned SM3_HI    = 3;
  localparam int unsigned SM3_LO    = 2;
  localparam int unsigned SM4_HI    = 1;
  localparam int unsigned SM4_LO    = 0;

  function automatic logic [1:0] insn_bs(input logic [INSN_W-1:0] insn);
    return insn[BS_HI:BS_LO];
  endfunction

endpackage

// File: rtl/crypto_seq_ctrl.sv
// Sequences one scalar-crypto instruction: latch operands, start the core,
// wait with timeout, then write the result back around delayed-load traffic.
module crypto_seq_ctrl
  import crypto_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [INSN_W-1:0] crypto_instruction,
  input  logic [31:0]       rs1_val,
  input  logic [31:0]       rs2_val,
  input  logic [4:0]        rd_in,
  input  logic              flush,
  input  logic              ld_wb_req,
  input  logic              cu_done,
  input  logic [31:0]       cu_result,
  output logic              cu_start,
  output logic              cu_abort,
  output logic [INSN_W-1:0] cu_insn,
  output logic [31:0]       cu_a,
  output logic [31:0]       cu_b,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              stall,
  output logic              busy,
  output logic              err
);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx, cnt_inc;
  logic [INSN_W-1:0]  insn_q;
  logic [31:0]        a_q, b_q, res_q;
  logic [4:0]         rd_q;
  logic               accept, take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      insn_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rd_q   <= '0;
      res_q  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        insn_q <= crypto_instruction;
        a_q    <= rs1_val;
        b_q    <= rs2_val;
        rd_q   <= rd_in;
      end
      if (take) res_q <= cu_result;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cnt_inc  = cnt + 1'b1;
    accept   = 1'b0;
    take     = 1'b0;
    cu_start = 1'b0;
    cu_abort = 1'b0;
    wb_we    = 1'b0;
    err      = 1'b0;
    stall    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (issue_valid && !flush) begin
          accept   = 1'b1;
          stall    = 1'b1;
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        stall  = 1'b1;
        cnt_nx = '0;
        if (flush) begin
          cu_abort = 1'b1;
          state_nx = S_IDLE;
        end else begin
          cu_start = 1'b1;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (flush) begin
          cu_abort = 1'b1;
          state_nx = S_IDLE;
        end else if (cu_done) begin
          take     = 1'b1;
          state_nx = S_WB;
        end else begin
          // Compare the incremented count so the timeout fires on the
          // TIMEOUT-th waiting cycle, in the same cycle the count reaches it.
          cnt_nx = cnt_inc;
          if (cnt_inc == CNT_W'(TIMEOUT)) begin
            err      = 1'b1;
            cu_abort = 1'b1;
            state_nx = S_IDLE;
          end
        end
      end
      S_WB: begin
        if (ld_wb_req) begin
          stall = 1'b1;
        end else begin
          wb_we    = (rd_q != '0);
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    // IDLE stall follows issue_valid; keep it quiet while reset is held
    if (rst) stall = 1'b0;
  end

  assign cu_insn = insn_q;
  assign cu_a    = a_q;
  assign cu_b    = b_q;
  assign wb_rd   = rd_q;
  assign wb_data = res_q;
  assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_crypto_seq_ctrl.sv
// Directed bench for crypto_seq_ctrl: stimulus pushes expected writes/aborts
// into a queue, a negedge monitor pops and compares them against DUT events.
module tb_crypto_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [19:0] crypto_instruction;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd_in;
  logic        flush, ld_wb_req, cu_done;
  logic [31:0] cu_result;
  logic        cu_start, cu_abort, wb_we, stall, busy, err;
  logic [19:0] cu_insn;
  logic [31:0] cu_a, cu_b, wb_data;
  logic [4:0]  wb_rd;

  crypto_seq_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid),
    .crypto_instruction(crypto_instruction), .rs1_val(rs1_val),
    .rs2_val(rs2_val), .rd_in(rd_in), .flush(flush), .ld_wb_req(ld_wb_req),
    .cu_done(cu_done), .cu_result(cu_result), .cu_start(cu_start),
    .cu_abort(cu_abort), .cu_insn(cu_insn), .cu_a(cu_a), .cu_b(cu_b),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    bit          is_write;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          err;
    int unsigned cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;

  task automatic expect_ev(input bit w, input logic [4:0] rd,
                           input logic [31:0] d, input bit er,
                           input int unsigned c);
    exp_t x;
    x.is_write = w;
    x.rd       = rd;
    x.data     = d;
    x.err      = er;
    x.cyc      = c;
    q.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] req);
    n_cmp = n_cmp + 1;
    if (got !== req) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%08h required 0x%08h (cyc %0d)", name, got, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (wb_we || cu_abort || err)) begin
      n_cmp = n_cmp + 1;
      if (q.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL unexpected_event: got we=%0b abort=%0b err=%0b cyc=%0d required no event",
                 wb_we, cu_abort, err, cyc);
      end else begin
        e = q.pop_front();
        if (wb_we !== e.is_write || cu_abort !== !e.is_write || err !== e.err ||
            cyc != e.cyc || (e.is_write && (wb_rd !== e.rd || wb_data !== e.data))) begin
          n_bad = n_bad + 1;
          $display("FAIL event: got we=%0b abort=%0b err=%0b rd=%0d data=0x%08h cyc=%0d required we=%0b err=%0b rd=%0d data=0x%08h cyc=%0d",
                   wb_we, cu_abort, err, wb_rd, wb_data, cyc,
                   e.is_write, e.err, e.rd, e.data, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nxt();
    @(negedge clk);
    tick();
  endtask

  task automatic do_accept(input logic [19:0] insn, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd,
                           output int unsigned c0);
    issue_valid        = 1'b1;
    crypto_instruction = insn;
    rs1_val            = a;
    rs2_val            = b;
    rd_in              = rd;
    c0                 = cyc;
    @(negedge clk);
    check("accept_stall", 32'(stall), 32'd1);
    tick();
    issue_valid        = 1'b0;
    crypto_instruction = '0;
    rs1_val            = '0;
    rs2_val            = '0;
    rd_in              = '0;
  endtask

  // Minimum-latency operation: start at T1, done at T2, write at T3
  task automatic full_op(input logic [19:0] insn, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] res);
    int unsigned c0;
    do_accept(insn, a, b, rd, c0);
    expect_ev(1'b1, rd, res, 1'b0, c0 + 3);
    @(negedge clk);
    check("t1_cu_start", 32'(cu_start), 32'd1);
    check("t1_cu_insn", 32'(cu_insn), 32'(insn));
    check("t1_cu_a", cu_a, a);
    check("t1_cu_b", cu_b, b);
    tick();
    cu_done   = 1'b1;
    cu_result = res;
    @(negedge clk);
    check("t2_cu_start", 32'(cu_start), 32'd0);
    tick();
    cu_done   = 1'b0;
    cu_result = '0;
    @(negedge clk);
    check("t3_stall", 32'(stall), 32'd0);
    tick();
    @(negedge clk);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_cu_a_stable", cu_a, a);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned c0;
    rst = 1'b1; issue_valid = 1'b0; crypto_instruction = '0;
    rs1_val = '0; rs2_val = '0; rd_in = '0; flush = 1'b0;
    ld_wb_req = 1'b0; cu_done = 1'b0; cu_result = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_start_abort_err_we", {28'd0, cu_start, cu_abort, err, wb_we}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    rst = 1'b0;
    tick();

    // AES op at minimum latency
    full_op(20'h84000, 32'h00112233, 32'h44556677, 5'd5, 32'hDEADBEEF);

    // load writeback owns the port for 3 cycles
    do_accept(20'h00400, 32'h1, 32'h2, 5'd7, c0);
    expect_ev(1'b1, 5'd7, 32'h12345678, 1'b0, c0 + 6);
    nxt();
    cu_done = 1'b1; cu_result = 32'h12345678;
    nxt();
    cu_done = 1'b0; cu_result = '0; ld_wb_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ld_hold_stall", 32'(stall), 32'd1);
      tick();
    end
    ld_wb_req = 1'b0;
    @(negedge clk);
    check("ld_release_stall", 32'(stall), 32'd0);
    tick();

    // no cu_done: timeout on the 15th WAIT cycle (T16)
    do_accept(20'h00010, 32'h3, 32'h4, 5'd9, c0);
    expect_ev(1'b0, '0, '0, 1'b1, c0 + 16);
    nxt();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 13) check("to_pre_err", 32'(err), 32'd0);
      tick();
    end
    @(negedge clk);
    check("to_busy_t16", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    check("to_idle", 32'(busy), 32'd0);
    check("to_stall", 32'(stall), 32'd0);
    tick();

    // cu_done coinciding with the timeout cycle wins
    do_accept(20'h00020, 32'h5, 32'h6, 5'd12, c0);
    expect_ev(1'b1, 5'd12, 32'h0BADF00D, 1'b0, c0 + 17);
    nxt();
    for (int i = 0; i < 14; i++) nxt();
    cu_done = 1'b1; cu_result = 32'h0BADF00D;
    @(negedge clk);
    check("to_done_err", 32'(err), 32'd0);
    tick();
    cu_done = 1'b0; cu_result = '0;
    nxt();
    nxt();

    // flush together with cu_done in WAIT: abort, result discarded
    do_accept(20'h00004, 32'h7, 32'h8, 5'd4, c0);
    expect_ev(1'b0, '0, '0, 1'b0, c0 + 2);
    nxt();
    flush = 1'b1; cu_done = 1'b1; cu_result = 32'hFFFF0000;
    nxt();
    flush = 1'b0; cu_done = 1'b0; cu_result = '0;
    @(negedge clk);
    check("flush_wait_idle", 32'(busy), 32'd0);
    check("flush_wait_discard", wb_data, 32'h0BADF00D);
    tick();

    // flush in ISSUE suppresses cu_start
    do_accept(20'h00001, 32'h9, 32'hA, 5'd2, c0);
    expect_ev(1'b0, '0, '0, 1'b0, c0 + 1);
    flush = 1'b1;
    @(negedge clk);
    check("flush_issue_start", 32'(cu_start), 32'd0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_issue_idle", 32'(busy), 32'd0);
    tick();

    // flush in IDLE blocks acceptance
    issue_valid = 1'b1; flush = 1'b1; rd_in = 5'd1;
    @(negedge clk);
    check("flush_idle_stall", 32'(stall), 32'd0);
    tick();
    issue_valid = 1'b0; flush = 1'b0; rd_in = '0;
    @(negedge clk);
    check("flush_idle_busy", 32'(busy), 32'd0);
    tick();

    // flush in WB does not cancel the write
    do_accept(20'h08000, 32'hB, 32'hC, 5'd11, c0);
    expect_ev(1'b1, 5'd11, 32'h0F0F0F0F, 1'b0, c0 + 3);
    nxt();
    cu_done = 1'b1; cu_result = 32'h0F0F0F0F;
    nxt();
    cu_done = 1'b0; cu_result = '0; flush = 1'b1;
    nxt();
    flush = 1'b0;

    // rd=0: completes with no write
    do_accept(20'h04000, 32'hD, 32'hE, 5'd0, c0);
    nxt();
    cu_done = 1'b1; cu_result = 32'h55AA55AA;
    nxt();
    cu_done = 1'b0; cu_result = '0;
    @(negedge clk);
    check("rd0_we", 32'(wb_we), 32'd0);
    check("rd0_busy_wb", 32'(busy), 32'd1);
    check("rd0_data", wb_data, 32'h55AA55AA);
    tick();
    @(negedge clk);
    check("rd0_idle", 32'(busy), 32'd0);
    tick();

    // asynchronous reset mid-WAIT, then a clean operation
    do_accept(20'h40100, 32'hAAAA0001, 32'hBBBB0002, 5'd9, c0);
    nxt();
    nxt();
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_pulses", {28'd0, cu_start, cu_abort, err, wb_we}, 32'd0);
    check("arst_stall", 32'(stall), 32'd0);
    check("arst_cu_insn", 32'(cu_insn), 32'd0);
    check("arst_cu_a", cu_a, 32'd0);
    check("arst_cu_b", cu_b, 32'd0);
    check("arst_wb_rd", 32'(wb_rd), 32'd0);
    check("arst_wb_data", wb_data, 32'd0);
    #1 rst = 1'b0;
    nxt();
    full_op(20'h08000, 32'h01020304, 32'h05060708, 5'd3, 32'hCAFEF00D);

    nxt();
    nxt();
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/crypto_seq_ctrl.md
CRYPTO_SEQ_CTRL -- requirements
Module: crypto_seq_ctrl

Interface
REQ-001 SHALL have these ports, clock and reset first (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- issue_valid  in  1  decode presents a scalar-crypto instruction.
- crypto_instruction  in  20  decoded crypto one-hot ops plus bs[1:0] in bits 19:18.
- rs1_val, rs2_val  in  32 each  operand values.
- rd_in  in  5  destination register (already rs1 for block ops).
- flush  in  1  pipeline flush.
- ld_wb_req  in  1  delayed-load writeback owns the register port this cycle.
- cu_done  in  1  crypto core result valid.
- cu_result  in  32  crypto core result.
- cu_start  out  1  one-cycle start pulse to crypto core.
- cu_abort  out  1  one-cycle cancel pulse to crypto core.
- cu_insn  out  20  latched instruction.
- cu_a, cu_b  out  32 each  latched operands.
- wb_we  out  1  register write enable.
- wb_rd  out  5  write address.
- wb_data  out  32  write data.
- stall  out  1  hold fetch/decode.
- busy  out  1  state not IDLE.
- err  out  1  one-cycle timeout pulse.

REQ-002 SHALL define one parameter: TIMEOUT, default 15, maximum WAIT cycles without cu_done.

Function
REQ-003 SHALL implement states IDLE, ISSUE, WAIT, WB.
REQ-004 IDLE: if issue_valid=1 and flush=0, SHALL latch crypto_instruction, rs1_val, rs2_val and rd_in, then go to ISSUE.
REQ-005 ISSUE: SHALL assert cu_start=1 for exactly one cycle, clear the timeout counter, then go to WAIT.
REQ-006 WAIT: if cu_done=1, SHALL latch cu_result and go to WB; cu_done is ignored in every other state.
REQ-007 WAIT without cu_done: the 4-bit counter SHALL increment; when counter==TIMEOUT, SHALL pulse err and cu_abort, skip the write, and return to IDLE.
REQ-008 WB: while ld_wb_req=1, SHALL hold with wb_we=0, because the load has priority.
REQ-009 WB with ld_wb_req=0: SHALL assert wb_we for one cycle with wb_rd=latched rd and wb_data=latched result, then go to IDLE.
REQ-010 In WB with latched rd==0, SHALL complete with wb_we=0.
REQ-011 Minimum latency SHALL be: accept at T0, cu_start at T1, cu_done at T2, wb_we at T3.
REQ-012 stall SHALL be combinational:
- 1 in IDLE when issue_valid=1 and flush=0;
- 1 in ISSUE and WAIT;
- 1 in WB unless wb completes this cycle;
- 0 otherwise.
REQ-013 flush=1 in ISSUE or WAIT SHALL return to IDLE, pulse cu_abort and suppress cu_start; flush in WB SHALL NOT cancel the write.
REQ-014 Simultaneous cu_done and counter==TIMEOUT SHALL resolve in favour of cu_done.
REQ-015 Simultaneous flush and cu_done in WAIT SHALL resolve in favour of flush; the result is discarded.
REQ-016 cu_insn, cu_a and cu_b SHALL remain stable from ISSUE until the next accept.
REQ-017 busy SHALL be 1 whenever state is not IDLE.

Reset
REQ-018 rst=1 SHALL immediately force: state=IDLE, counter=0, all latches=0, and cu_start, cu_abort, wb_we, err all 0.
REQ-019 Reset mid-operation SHALL drop any pending result with no write and no abort pulse.

Structure
REQ-020 The shared package crypto_pkg SHALL hold:
- the state enum;
- TIMEOUT_DEFAULT=15;
- crypto_instruction field indices (bs=19:18, aes 17:14, sha256 13:10, sha512 9:4, sm3 3:2, sm4 1:0).
REQ-021 SHALL be a single module with no sub-modules; the counter and FSM are inline.

Verification
REQ-022 SHALL cover these directed scenarios:
- AES op, rs1=0x00112233, rd=5, cu_done at T2 with 0xDEADBEEF -> cu_start at T1, wb_we at T3, wb_rd=5, wb_data=0xDEADBEEF.
- ld_wb_req=1 for 3 cycles while in WB -> wb_we delayed exactly 3 cycles; stall held until the write.
- No cu_done -> err and cu_abort pulse on the 15th WAIT cycle; wb_we never asserts; returns to IDLE.
- flush in WAIT together with cu_done -> cu_abort=1, no write, IDLE next cycle.
- rd=0 with cu_done -> FSM returns to IDLE; wb_we stays 0.
- rst asserted mid-WAIT, asynchronously -> all outputs 0 immediately; after release, a new issue_valid is accepted normally.
